// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU-op width, forward-select encodings and
// the forward-priority helper used by the hazard/forward logic.
// No ports (package).
package pipe_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB   = 2'b01;  // operand from EX/MEM (older producer)
  localparam logic [1:0] FWD_MEM  = 2'b10;  // operand from ID/EX (newer producer)

  // The newer producer always wins: it holds the most recent write to the register.
  function automatic logic [1:0] fwd_pick(input logic newer_hit, input logic older_hit);
    if (newer_hit)      return FWD_MEM;
    else if (older_hit) return FWD_WB;
    else                return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use stall detection and next-cycle forward selects.
// Inputs: decoded ID source regs, current ID/EX producer, EX/MEM producer, branch flush.
// Outputs: stall (to PC and IF/ID), fwd_a_nxt / fwd_b_nxt (registered by the stage).
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic       if_id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_ex_valid,
  input  logic       id_ex_memread,
  input  logic       id_ex_regwrite,
  input  logic [4:0] id_ex_rd,
  input  logic [4:0] ex_mem_rd,
  input  logic       ex_mem_regwrite,
  input  logic       ex_pc_src,
  output logic       stall,
  output logic [1:0] fwd_a_nxt,
  output logic [1:0] fwd_b_nxt
);

  logic ex_rd_nz;
  logic mem_rd_nz;
  logic new_a, new_b, old_a, old_b;

  // x0 is hardwired to zero, so a write to it is never a real producer.
  assign ex_rd_nz  = (id_ex_rd != 5'd0);
  assign mem_rd_nz = (ex_mem_rd != 5'd0);

  // A load in EX cannot forward its data in time; hold the consumer one cycle.
  // A taken branch flushes the consumer anyway, so the stall is suppressed.
  assign stall = if_id_valid & id_ex_valid & id_ex_memread & ex_rd_nz &
                 ((id_ex_rd == id_rs1) | (id_ex_rd == id_rs2)) & ~ex_pc_src;

  assign new_a = id_ex_valid & id_ex_regwrite & ex_rd_nz & (id_ex_rd == id_rs1);
  assign new_b = id_ex_valid & id_ex_regwrite & ex_rd_nz & (id_ex_rd == id_rs2);
  assign old_a = ex_mem_regwrite & mem_rd_nz & (ex_mem_rd == id_rs1);
  assign old_b = ex_mem_regwrite & mem_rd_nz & (ex_mem_rd == id_rs2);

  assign fwd_a_nxt = fwd_pick(new_a, old_a);
  assign fwd_b_nxt = fwd_pick(new_b, old_b);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and forward-select generation.
// Inputs: ID fields/control, EX branch resolution, EX/MEM destination. Outputs: registered
// id_ex_* copies, fwd_a/fwd_b, combinational stall, saturating stall/flush bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  // ID side
  input  logic                if_id_valid,
  input  logic [XLEN-1:0]     if_id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_alu_src,
  input  logic                id_memread,
  input  logic                id_memwrite,
  input  logic                id_mem_to_reg,
  input  logic                id_regwrite,
  input  logic                id_branch,
  // feedback
  input  logic                ex_pc_src,
  input  logic [4:0]          ex_mem_rd,
  input  logic                ex_mem_regwrite,
  // ID/EX register
  output logic                id_ex_valid,
  output logic [XLEN-1:0]     id_ex_pc,
  output logic [4:0]          id_ex_rs1,
  output logic [4:0]          id_ex_rs2,
  output logic [4:0]          id_ex_rd,
  output logic [XLEN-1:0]     id_ex_rs1_data,
  output logic [XLEN-1:0]     id_ex_rs2_data,
  output logic [XLEN-1:0]     id_ex_imm,
  output logic [ALU_OP_W-1:0] id_ex_alu_op,
  output logic                id_ex_alu_src,
  output logic                id_ex_memread,
  output logic                id_ex_memwrite,
  output logic                id_ex_mem_to_reg,
  output logic                id_ex_regwrite,
  output logic                id_ex_branch,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall,
  output logic [CNTW-1:0]     bubble_cnt
);

  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;
  logic       hazard_bubble;
  logic       bubble;

  hazard_fwd_unit u_hazard (
    .if_id_valid     (if_id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_ex_valid     (id_ex_valid),
    .id_ex_memread   (id_ex_memread),
    .id_ex_regwrite  (id_ex_regwrite),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_pc_src       (ex_pc_src),
    .stall           (stall),
    .fwd_a_nxt       (fwd_a_nxt),
    .fwd_b_nxt       (fwd_b_nxt)
  );

  // Stall and flush in the same cycle form a single counted bubble; an
  // empty ID slot also loads a bubble but is not a hazard and is not counted.
  assign hazard_bubble = stall | ex_pc_src;
  assign bubble        = hazard_bubble | ~if_id_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_valid      <= 1'b0;
      id_ex_pc         <= '0;
      id_ex_rs1        <= '0;
      id_ex_rs2        <= '0;
      id_ex_rd         <= '0;
      id_ex_rs1_data   <= '0;
      id_ex_rs2_data   <= '0;
      id_ex_imm        <= '0;
      id_ex_alu_op     <= '0;
      id_ex_alu_src    <= 1'b0;
      id_ex_memread    <= 1'b0;
      id_ex_memwrite   <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_regwrite   <= 1'b0;
      id_ex_branch     <= 1'b0;
      fwd_a            <= FWD_NONE;
      fwd_b            <= FWD_NONE;
      bubble_cnt       <= '0;
    end else begin
      // Data fields are loaded unconditionally; a bubble is identified by
      // id_ex_valid=0 with zero control and rd, so stale data is harmless.
      id_ex_pc       <= if_id_pc;
      id_ex_rs1      <= id_rs1;
      id_ex_rs2      <= id_rs2;
      id_ex_rs1_data <= id_rs1_data;
      id_ex_rs2_data <= id_rs2_data;
      id_ex_imm      <= id_imm;
      if (bubble) begin
        id_ex_valid      <= 1'b0;
        id_ex_rd         <= '0;
        id_ex_alu_op     <= '0;
        id_ex_alu_src    <= 1'b0;
        id_ex_memread    <= 1'b0;
        id_ex_memwrite   <= 1'b0;
        id_ex_mem_to_reg <= 1'b0;
        id_ex_regwrite   <= 1'b0;
        id_ex_branch     <= 1'b0;
        fwd_a            <= FWD_NONE;
        fwd_b            <= FWD_NONE;
      end else begin
        id_ex_valid      <= 1'b1;
        id_ex_rd         <= id_rd;
        id_ex_alu_op     <= id_alu_op;
        id_ex_alu_src    <= id_alu_src;
        id_ex_memread    <= id_memread;
        id_ex_memwrite   <= id_memwrite;
        id_ex_mem_to_reg <= id_mem_to_reg;
        id_ex_regwrite   <= id_regwrite;
        id_ex_branch     <= id_branch;
        fwd_a            <= fwd_a_nxt;
        fwd_b            <= fwd_b_nxt;
      end
      if (hazard_bubble && (bubble_cnt != {CNTW{1'b1}}))
        bubble_cnt <= bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_memread, id_memwrite, id_mem_to_reg, id_regwrite, id_branch;
  logic        ex_pc_src;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwrite;

  logic        id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src, id_ex_memread, id_ex_memwrite, id_ex_mem_to_reg, id_ex_regwrite, id_ex_branch;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] bubble_cnt;

  // second instance with a 2-bit counter for saturation
  logic        s_valid;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_alu_op;
  logic        s_alu_src, s_memread, s_memwrite, s_mem_to_reg, s_regwrite, s_branch;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_stall;
  logic [1:0]  s_bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_mem_to_reg(id_mem_to_reg), .id_regwrite(id_regwrite),
    .id_branch(id_branch), .ex_pc_src(ex_pc_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1),
    .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_alu_op(id_ex_alu_op),
    .id_ex_alu_src(id_ex_alu_src), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_mem_to_reg(id_ex_mem_to_reg),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_branch(id_ex_branch),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNTW(2)) dut_s (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_mem_to_reg(id_mem_to_reg), .id_regwrite(id_regwrite),
    .id_branch(id_branch), .ex_pc_src(ex_pc_src), .ex_mem_rd(ex_mem_rd),
    .ex_mem_regwrite(ex_mem_regwrite),
    .id_ex_valid(s_valid), .id_ex_pc(s_pc), .id_ex_rs1(s_rs1),
    .id_ex_rs2(s_rs2), .id_ex_rd(s_rd), .id_ex_rs1_data(s_rs1_data),
    .id_ex_rs2_data(s_rs2_data), .id_ex_imm(s_imm), .id_ex_alu_op(s_alu_op),
    .id_ex_alu_src(s_alu_src), .id_ex_memread(s_memread),
    .id_ex_memwrite(s_memwrite), .id_ex_mem_to_reg(s_mem_to_reg),
    .id_ex_regwrite(s_regwrite), .id_ex_branch(s_branch),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // control bundle order: {alu_src, memread, memwrite, mem_to_reg, regwrite, branch}
  localparam logic [5:0] C_ALU = 6'b000010;
  localparam logic [5:0] C_LW  = 6'b110110;
  localparam logic [5:0] C_SW  = 6'b101000;
  localparam logic [5:0] C_BR  = 6'b000001;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    bit          data_known;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [5:0]  ctrl;
    logic [1:0]  fa, fb;
    int unsigned cnt;
  } mstate_t;

  mstate_t m;

  function automatic void model_reset();
    m.valid = 0; m.data_known = 1;
    m.pc = 0; m.rs1_data = 0; m.rs2_data = 0; m.imm = 0;
    m.rs1 = 0; m.rs2 = 0; m.rd = 0; m.alu_op = 0; m.ctrl = 0;
    m.fa = 0; m.fb = 0; m.cnt = 0;
  endfunction

  // load-use hazard: instruction in EX is a load whose target is read by ID
  function automatic bit model_stall();
    bit ex_is_load = m.valid && m.ctrl[4] && m.rd != 0;
    bit uses       = (m.rd == id_rs1) || (m.rd == id_rs2);
    if (rst == 1'b0) return 0;
    return if_id_valid && ex_is_load && uses && !ex_pc_src;
  endfunction

  // where the operand for source register r must come from
  function automatic logic [1:0] model_src(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (m.valid && m.ctrl[1] && m.rd == r) return 2'b10;
    if (ex_mem_regwrite && ex_mem_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void model_edge();
    bit hazard = model_stall() || ex_pc_src;
    logic [1:0] na, nb;
    na = model_src(id_rs1);
    nb = model_src(id_rs2);
    if (hazard || !if_id_valid) begin
      m.valid = 0; m.data_known = 0; m.rd = 0; m.alu_op = 0; m.ctrl = 0;
      m.fa = 0; m.fb = 0;
      if (hazard) m.cnt++;
    end else begin
      m.valid = 1; m.data_known = 1;
      m.pc = if_id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.rs1_data = id_rs1_data; m.rs2_data = id_rs2_data; m.imm = id_imm;
      m.alu_op = id_alu_op;
      m.ctrl = {id_alu_src, id_memread, id_memwrite, id_mem_to_reg, id_regwrite, id_branch};
      m.fa = na; m.fb = nb;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned c16 = (m.cnt > 65535) ? 65535 : m.cnt;
    int unsigned c2  = (m.cnt > 3) ? 3 : m.cnt;
    chk("stall", stall, model_stall());
    chk("valid", id_ex_valid, m.valid);
    chk("rd", id_ex_rd, m.rd);
    chk("alu_op", id_ex_alu_op, m.alu_op);
    chk("ctrl", {id_ex_alu_src, id_ex_memread, id_ex_memwrite, id_ex_mem_to_reg,
                 id_ex_regwrite, id_ex_branch}, m.ctrl);
    chk("fwd_a", fwd_a, m.fa);
    chk("fwd_b", fwd_b, m.fb);
    chk("bubble_cnt", bubble_cnt, c16);
    chk("s_valid", s_valid, m.valid);
    chk("s_bubble_cnt", s_bubble_cnt, c2);
    if (m.data_known) begin
      chk("pc", id_ex_pc, m.pc);
      chk("rs1", id_ex_rs1, m.rs1);
      chk("rs2", id_ex_rs2, m.rs2);
      chk("rs1_data", id_ex_rs1_data, m.rs1_data);
      chk("rs2_data", id_ex_rs2_data, m.rs2_data);
      chk("imm", id_ex_imm, m.imm);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic [3:0] op,
                          input logic [5:0] ctrl);
    if_id_valid = v; if_id_pc = pc;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = pc ^ 32'h1111_0000; id_rs2_data = pc + 32'h200; id_imm = ~pc;
    id_alu_op = op;
    {id_alu_src, id_memread, id_memwrite, id_mem_to_reg, id_regwrite, id_branch} = ctrl;
  endtask

  task automatic set_fb(input logic pcs, input logic [4:0] mrd, input logic mrw);
    ex_pc_src = pcs; ex_mem_rd = mrd; ex_mem_regwrite = mrw;
  endtask

  // entered at posedge+1; inputs are already set and stable
  task automatic step();
    #2;
    chk("stall_pre", stall, model_stall());
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 6'b0);
    set_fb(0, 0, 0);
    model_reset();
    #2;
    check_all();
    chk("reset_valid_lit", id_ex_valid, 0);
    chk("reset_stall_lit", stall, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // plain capture
    drive_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 4'd2, C_ALU);
    step();
    chk("cap_valid_lit", id_ex_valid, 1);
    chk("cap_rd_lit", id_ex_rd, 3);
    chk("cap_pc_lit", id_ex_pc, 32'h100);

    // newer producer beats older for rs2 (both write x3)
    drive_id(1, 32'h104, 5'd7, 5'd3, 5'd4, 4'd1, C_ALU);
    set_fb(0, 5'd3, 1);
    step();
    chk("prio_fwd_b_lit", fwd_b, 2'b10);
    chk("prio_fwd_a_lit", fwd_a, 2'b00);

    // rs1 from EX/MEM, rs2 from ID/EX (x4)
    drive_id(1, 32'h108, 5'd9, 5'd4, 5'd6, 4'd3, C_SW);
    set_fb(0, 5'd9, 1);
    step();
    chk("mix_fwd_a_lit", fwd_a, 2'b01);
    chk("mix_fwd_b_lit", fwd_b, 2'b10);

    // store (no regwrite) in EX: no ID/EX forward; EX/MEM write disabled
    drive_id(1, 32'h10c, 5'd6, 5'd9, 5'd8, 4'd0, C_ALU);
    set_fb(0, 5'd9, 0);
    step();
    chk("norw_fwd_lit", {fwd_a, fwd_b}, 4'b0000);

    // load-use: lw x5 then add rs1=x5
    drive_id(1, 32'h110, 5'd1, 5'd2, 5'd5, 4'd0, C_LW);
    set_fb(0, 5'd0, 0);
    step();
    drive_id(1, 32'h114, 5'd5, 5'd6, 5'd7, 4'd2, C_ALU);
    set_fb(0, 5'd5, 1);
    #1;
    chk("lu_stall_lit", stall, 1);
    step();
    chk("lu_bubble_valid_lit", id_ex_valid, 0);
    chk("lu_bubble_cnt_lit", bubble_cnt, 1);
    chk("lu_bubble_ctrl_lit", {id_ex_memread, id_ex_regwrite, id_ex_rd}, 7'd0);
    step();
    chk("lu_cap_valid_lit", id_ex_valid, 1);
    chk("lu_cap_fwd_a_lit", fwd_a, 2'b01);
    chk("lu_cap_pc_lit", id_ex_pc, 32'h114);

    // x0 never stalls or forwards
    drive_id(1, 32'h118, 5'd1, 5'd1, 5'd0, 4'd0, C_LW);
    set_fb(0, 5'd0, 0);
    step();
    drive_id(1, 32'h11c, 5'd0, 5'd0, 5'd2, 4'd2, C_ALU);
    set_fb(0, 5'd0, 1);
    #1;
    chk("x0_stall_lit", stall, 0);
    step();
    chk("x0_fwd_a_lit", fwd_a, 2'b00);
    chk("x0_fwd_b_lit", fwd_b, 2'b00);

    // flush and stall together: one bubble, one count
    drive_id(1, 32'h120, 5'd1, 5'd2, 5'd8, 4'd0, C_LW);
    set_fb(0, 5'd0, 0);
    step();
    drive_id(1, 32'h124, 5'd3, 5'd8, 5'd9, 4'd2, C_ALU);
    #1;
    chk("fs_stall_only_lit", stall, 1);
    ex_pc_src = 1;
    #1;
    chk("fs_stall_lit", stall, 0);
    step();
    chk("fs_valid_lit", id_ex_valid, 0);
    chk("fs_cnt_lit", bubble_cnt, 2);

    // empty ID slot: bubble, not counted
    drive_id(0, 32'h128, 5'd1, 5'd2, 5'd3, 4'd2, C_BR);
    set_fb(0, 5'd0, 0);
    step();
    chk("inv_valid_lit", id_ex_valid, 0);
    chk("inv_cnt_lit", bubble_cnt, 2);

    // branch capture, then asynchronous reset mid-stream
    drive_id(1, 32'h12c, 5'd4, 5'd5, 5'd0, 4'd5, C_BR);
    step();
    chk("br_branch_lit", id_ex_branch, 1);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_valid_lit", id_ex_valid, 0);
    chk("arst_cnt_lit", bubble_cnt, 0);
    chk("arst_pc_lit", id_ex_pc, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // reset during a stall: stalled instruction captured right after reset
    drive_id(1, 32'h200, 5'd1, 5'd2, 5'd10, 4'd0, C_LW);
    step();
    drive_id(1, 32'h204, 5'd10, 5'd3, 5'd11, 4'd2, C_ALU);
    #1;
    chk("rs_stall_lit", stall, 1);
    do_reset();
    step();
    chk("rs_cap_valid_lit", id_ex_valid, 1);
    chk("rs_cap_pc_lit", id_ex_pc, 32'h204);
    chk("rs_cnt_lit", bubble_cnt, 0);

    // saturation of the 2-bit counter over five flush edges
    do_reset();
    drive_id(1, 32'h300, 5'd1, 5'd2, 5'd3, 4'd2, C_ALU);
    set_fb(1, 5'd0, 0);
    begin
      logic [1:0] sat_seq [5];
      sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("sat_s_cnt_lit", s_bubble_cnt, sat_seq[i]);
        chk("sat_cnt16_lit", bubble_cnt, i + 1);
      end
    end
    set_fb(0, 5'd0, 0);
    step();
    chk("sat_resume_valid_lit", id_ex_valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNTW, default 16, bubble-counter width.
REQ-003 SHALL have ports: clk input 1, sole clock, all state on rising edge; rst input 1, asynchronous active-low reset.
REQ-004 SHALL have ID-side inputs: if_id_valid 1; if_id_pc XLEN; id_rs1, id_rs2, id_rd 5 each; id_rs1_data, id_rs2_data, id_imm XLEN each.
REQ-005 SHALL have ID-side control inputs: id_alu_op 4; id_alu_src, id_memread, id_memwrite, id_mem_to_reg, id_regwrite, id_branch 1 each.
REQ-006 SHALL have feedback inputs: ex_pc_src 1 (branch taken, resolved in EX); ex_mem_rd 5; ex_mem_regwrite 1.
REQ-007 SHALL have outputs: id_ex_valid 1, plus registered copies id_ex_<field> of every REQ-004/005 field except if_id_valid (id_ex_pc onward).
REQ-008 SHALL have outputs: fwd_a, fwd_b 2 each (registered forward selects); stall 1 (combinational, to PC and IF/ID); bubble_cnt CNTW.

Function
REQ-009 SHALL assert stall = if_id_valid & id_ex_valid & id_ex_memread & id_ex_rd!=0 & (id_ex_rd==id_rs1 | id_ex_rd==id_rs2) & !ex_pc_src.
REQ-010 SHALL, on an edge with ex_pc_src=1, load a bubble: id_ex_valid=0, all control outputs 0, id_ex_rd=0, fwd_a=fwd_b=0; flush overrides stall.
REQ-011 SHALL, on an edge with stall=1, load a bubble as in REQ-010; the ID instruction is held upstream and captured on the next non-stall edge.
REQ-012 SHALL, on an edge with if_id_valid=0 and no flush/stall, load a bubble.
REQ-013 SHALL otherwise capture all ID fields with id_ex_valid=1; latency ID->EX exactly one cycle.
REQ-014 SHALL compute fwd_a at capture: 2'b10 if id_ex_valid & id_ex_regwrite & id_ex_rd!=0 & id_ex_rd==id_rs1; else 2'b01 if ex_mem_regwrite & ex_mem_rd!=0 & ex_mem_rd==id_rs1; else 2'b00.
REQ-015 SHALL compute fwd_b identically against id_rs2; 2'b10 (newer) wins over 2'b01 when both match.
REQ-016 SHALL never forward for register x0.
REQ-017 SHALL increment bubble_cnt by 1 on every edge loading a bubble caused by stall or flush (not by REQ-012), saturating at all-ones.
REQ-018 SHALL treat stall and flush in the same cycle as one bubble, one count.
REQ-019 SHALL pass data fields unchanged in a bubble only if convenient; bubble correctness is defined solely by id_ex_valid=0 and zero control.

Reset
REQ-020 SHALL, while rst=0, immediately force id_ex_valid=0, all control outputs 0, all 5-bit fields 0, all XLEN fields 0, fwd_a=fwd_b=0, bubble_cnt=0.
REQ-021 SHALL drive stall=0 while rst=0 (follows from id_ex_valid=0).
REQ-022 SHALL resume capture on the first rising edge after rst deasserts; reset mid-stall discards the stalled instruction's bubble state.

Structure
REQ-023 SHALL take fwd select encodings (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) and ALU-op width from shared package pipe_pkg.
REQ-024 SHALL contain one sub-module, hazard_fwd_unit, combinational: stall, next fwd_a, next fwd_b.
REQ-025 SHALL keep all sequential state in id_ex_stage itself.

Verification
REQ-026 Reset: rst=0 mid-stream with id_ex_valid=1 -> all outputs 0 without a clock edge; bubble_cnt=0.
REQ-027 Load-use: id_ex lw x5 (memread=1, rd=5), ID add rs1=5 -> stall=1 same cycle, next edge id_ex_valid=0, bubble_cnt=1; following edge captures add with fwd_a=2'b01 when ex_mem_rd=5, ex_mem_regwrite=1.
REQ-028 Forward priority: id_ex_rd=3 regwrite=1, ex_mem_rd=3 regwrite=1, ID rs2=3 -> fwd_b=2'b10 after edge.
REQ-029 x0: id_ex_rd=0 regwrite=1 memread=1, ID rs1=0 -> stall=0, fwd_a=2'b00.
REQ-030 Flush+stall: load-use condition with ex_pc_src=1 -> stall=0, bubble loaded, bubble_cnt +1 only.
REQ-031 Saturation: CNTW=2, five consecutive flush edges -> bubble_cnt sequence 1,2,3,3,3.
